serial_addsub: RTL and testbench

SERIAL_ADDSUB -- requirements
Module: serial_addsub

---
 rtl/serial_addsub.sv | 116 +++++++++++
 tb/tb_serial_addsub.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one bit per clock, LSB first, with registered
// result, final carry and two's-complement overflow.
//
// state | meaning
// IDLE  | waiting for start
// SHIFT | processing one operand bit per cycle
// DONE  | result valid, done pulse; start here chains the next operation
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] z,
    output logic             carry_out,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state, state_next;
    logic   load, step;

    logic [WIDTH-1:0] a_reg, b_reg, r_reg;
    logic             c_reg;
    logic [CW-1:0]    bit_cnt;
    logic             bit_sum, bit_carry, last_bit;

    assign bit_sum   = a_reg[0] ^ b_reg[0] ^ c_reg;
    assign bit_carry = (a_reg[0] & b_reg[0]) | (a_reg[0] & c_reg) | (b_reg[0] & c_reg);
    assign last_bit  = (bit_cnt == LAST_BIT);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                step = 1'b1;
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    load       = 1'b1;
                    state_next = SHIFT;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Subtraction is x + ~y + 1: the inverted operand plus a carry-in of 1.
    always_ff @(posedge clock) begin
        if (reset) begin
            a_reg     <= '0;
            b_reg     <= '0;
            r_reg     <= '0;
            c_reg     <= 1'b0;
            bit_cnt   <= '0;
            z         <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else if (load) begin
            a_reg   <= x;
            b_reg   <= sub ? ~y : y;
            c_reg   <= sub;
            bit_cnt <= '0;
        end else if (step) begin
            a_reg   <= a_reg >> 1;
            b_reg   <= b_reg >> 1;
            r_reg   <= {bit_sum, r_reg[WIDTH-1:1]};
            c_reg   <= bit_carry;
            bit_cnt <= bit_cnt + 1'b1;
            if (last_bit) begin
                z         <= {bit_sum, r_reg[WIDTH-1:1]};
                carry_out <= bit_carry;
                overflow  <= c_reg ^ bit_carry;
            end
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Directed and randomized checks of serial_addsub against an arithmetic
// reference model (WIDTH = 8).
module tb_serial_addsub;

    localparam int W = 8;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic         sub;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] z;
    logic         carry_out;
    logic         overflow;
    logic         busy;
    logic         done;

    int           n_assert = 0;
    int           n_fail   = 0;
    logic [W-1:0] z_prev;
    logic         co_prev;
    logic         ov_prev;
    longint       last_done_t;
    longint       t_first;

    serial_addsub #(.WIDTH(W)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .sub       (sub),
        .x         (x),
        .y         (y),
        .z         (z),
        .carry_out (carry_out),
        .overflow  (overflow),
        .busy      (busy),
        .done      (done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Plain integer arithmetic: unsigned result for z/carry, signed for overflow.
    function automatic void ref_op(input logic [W-1:0] xv, input logic [W-1:0] yv,
                                   input logic sv, output logic [W-1:0] zr,
                                   output logic cr, output logic vr);
        int ux, uy, sx, sy, us, ss;
        ux = int'(xv);
        uy = int'(yv);
        sx = int'($signed(xv));
        sy = int'($signed(yv));
        us = sv ? ux - uy : ux + uy;
        ss = sv ? sx - sy : sx + sy;
        zr = W'(us);
        cr = sv ? (ux >= uy) : (us >= 2**W);
        vr = (ss > 2**(W-1) - 1) || (ss < -(2**(W-1)));
    endfunction

    // Start one operation, scramble inputs while it runs, optionally pulse
    // start during SHIFT, and check the result on the done cycle.
    task automatic run_op(input string tag, input logic [W-1:0] xv, input logic [W-1:0] yv,
                          input logic sv, input int pulse_at, input bit idle_after);
        logic [W-1:0] ez;
        logic         ec, ev;
        ref_op(xv, yv, sv, ez, ec, ev);
        @(negedge clock);
        start = 1'b1; x = xv; y = yv; sub = sv;
        @(posedge clock); #1;
        start = 1'b0; x = W'($urandom); y = W'($urandom); sub = 1'($urandom);
        for (int k = 1; k <= W; k++) begin
            chk({tag, "_busy"}, 32'(busy), 32'd1);
            chk({tag, "_nodone"}, 32'(done), 32'd0);
            chk({tag, "_hold"}, 32'({z, carry_out, overflow}), 32'({z_prev, co_prev, ov_prev}));
            if (k == pulse_at) begin
                @(negedge clock);
                start = 1'b1; x = '1; y = '1; sub = 1'($urandom);
            end
            @(posedge clock); #1;
            start = 1'b0;
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_busy_end"}, 32'(busy), 32'd0);
        chk({tag, "_z"}, 32'(z), 32'(ez));
        chk({tag, "_co"}, 32'(carry_out), 32'(ec));
        chk({tag, "_ov"}, 32'(overflow), 32'(ev));
        last_done_t = $time;
        z_prev  = ez;
        co_prev = ec;
        ov_prev = ev;
        if (idle_after) begin
            @(posedge clock); #1;
            chk({tag, "_idle_done"}, 32'(done), 32'd0);
            chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; sub = 1'b0; x = '0; y = '0;
        z_prev = '0; co_prev = 1'b0; ov_prev = 1'b0; last_done_t = 0; t_first = 0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_outs", 32'({z, carry_out, overflow, busy, done}), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        run_op("add_55_aa", 8'h55, 8'hAA, 1'b0, 0, 1'b1);
        chk("add_55_aa_spec", 32'({z, carry_out, overflow}), 32'({8'hFF, 1'b0, 1'b0}));
        run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 0, 1'b1);
        chk("add_ff_01_spec", 32'({z, carry_out, overflow}), 32'({8'h00, 1'b1, 1'b0}));
        run_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 0, 1'b1);
        chk("add_7f_01_spec", 32'({z, carry_out, overflow}), 32'({8'h80, 1'b0, 1'b1}));
        run_op("sub_00_01", 8'h00, 8'h01, 1'b1, 0, 1'b1);
        chk("sub_00_01_spec", 32'({z, carry_out, overflow}), 32'({8'hFF, 1'b0, 1'b0}));
        run_op("sub_80_01", 8'h80, 8'h01, 1'b1, 0, 1'b1);
        chk("sub_80_01_spec", 32'({z, carry_out, overflow}), 32'({8'h7F, 1'b1, 1'b1}));

        // Reset four edges into an operation: everything clears, no done follows.
        @(negedge clock);
        start = 1'b1; x = 8'h55; y = 8'hAA; sub = 1'b0;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        chk("midrst_outs", 32'({z, carry_out, overflow, busy, done}), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        z_prev = '0; co_prev = 1'b0; ov_prev = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            chk("midrst_nodone", 32'({busy, done}), 32'd0);
        end
        run_op("after_rst", 8'h01, 8'h02, 1'b0, 0, 1'b1);
        chk("after_rst_spec", 32'(z), 32'h03);

        run_op("start_busy", 8'h10, 8'h20, 1'b0, 3, 1'b1);
        chk("start_busy_spec", 32'(z), 32'h30);

        run_op("b2b_first", 8'h05, 8'h06, 1'b0, 0, 1'b0);
        t_first = last_done_t;
        run_op("b2b_second", 8'h03, 8'h01, 1'b1, 0, 1'b1);
        chk("b2b_gap", 32'(last_done_t - t_first), 32'd90);
        chk("b2b_spec", 32'({z, carry_out}), 32'({8'h02, 1'b1}));

        for (int i = 0; i < 40; i++) begin
            run_op("rand", W'($urandom), W'($urandom), 1'($urandom),
                   int'($urandom_range(0, W)), (i == 39) ? 1'b1 : 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
